multi_key_debounce: RTL and testbench
=====================================

// Module: multi_key_debounce
// PURPOSE
//  N-channel push-button front end: synchronises, debounces and classifies raw keys
//  (DE2-115 KEY/SW) into level, press, release, long-press and auto-repeat events.
//  Successor to the single-key debouncer: width, thresholds and polarity are
//  parametrised, and long-press/repeat detection is added. Sits between board pins
//  and game/VGA control logic in the top level, clocked from CLOCK_50.
// PARAMETERS
//  N_KEYS        4        number of independent key channels
//  ACTIVE_LOW    1        1: raw pin 0 = pressed (DE2-115 KEYs); 0: raw 1 = pressed
//  DEB_CYCLES    500000   consecutive stable cycles to accept a change (10 ms @50 MHz)
//  LONG_CYCLES   50000000 held cycles, counted from the press pulse, that fire o_long
//  REPEAT_CYCLES 10000000 period of o_repeat after o_long (auto-repeat)
// PORTS
//  clk          in   1       system clock (CLOCK_50)
//  rst_n        in   1       reset, asynchronous, active-low
//  i_key        in   N_KEYS  raw asynchronous key pins
//  i_repeat_en  in   N_KEYS  per-channel auto-repeat enable
//  o_level      out  N_KEYS  debounced state, 1 = pressed
//  o_press      out  N_KEYS  1-cycle pulse on accepted press
//  o_release    out  N_KEYS  1-cycle pulse on accepted release
//  o_long       out  N_KEYS  1-cycle pulse, once per press, at LONG_CYCLES held
//  o_repeat     out  N_KEYS  1-cycle pulse every REPEAT_CYCLES after o_long
// BEHAVIOUR
//  Clock/reset: single clock clk; reset is asynchronous, active-low (rst_n).
//  Reset: all outputs 0; synchroniser flops load the released pin level
//   (ACTIVE_LOW ? 1 : 0); debounce/hold counters 0; FSMs IDLE.
//  Sync: 2-flop synchroniser per channel, then polarity-normalised (1 = pressed).
//  Debounce: counter increments each cycle sync != o_level, clears when equal.
//   When it reaches DEB_CYCLES-1 while still differing, o_level flips next cycle
//   and the counter clears. Glitches shorter than DEB_CYCLES leave no trace.
//   Latency raw edge -> o_level = DEB_CYCLES+2 cycles.
//  o_press/o_release assert in the first cycle o_level shows its new value.
//  Per-channel FSM (key_state_e):
//   K_IDLE   : o_level 0. Accepted press -> K_HELD, hold counter cleared.
//   K_HELD   : hold counter +1/cycle; at LONG_CYCLES-1 -> pulse o_long, -> K_REPEAT,
//              repeat counter cleared. Accepted release -> K_IDLE.
//   K_REPEAT : repeat counter +1/cycle only while i_repeat_en; at REPEAT_CYCLES-1 pulse
//              o_repeat, counter clears. i_repeat_en low freezes counter, no pulses.
//              Accepted release -> K_IDLE.
//  Release wins over a coincident long/repeat terminal count: o_release pulses,
//   o_long/o_repeat do not. At most one of press/release/long/repeat per channel/cycle.
//  Counters: widths $clog2(param+1); never wrap (cleared on state change/terminal).
//  Channels fully independent; simultaneous events on several channels all reported.
//  Reset mid-operation: everything returns to reset values in the same edge-free
//   instant; a key still held after rst_n rises is re-accepted as a new press.
// STRUCTURE
//  Package key_pkg: typedef enum logic [1:0] key_state_e {K_IDLE, K_HELD, K_REPEAT};
//   localparam function for counter widths.
//  Sub-module key_channel (sync + debounce + FSM, one key), instantiated N_KEYS times
//   via generate; top only fans out vectors.
// TESTING (bench params: N_KEYS=4, DEB_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=10)
//  Reset: rst_n low, i_key=4'hF -> all outputs 0; release rst_n, hold 50 cycles -> no pulses.
//  Clean press ch0 (i_key[0] 1->0) -> o_level[0] and o_press[0] high exactly 10 cycles later.
//  Bounce: i_key[1] low 5 cycles, high 3, low steady -> one o_press[1], 10 cycles after last edge.
//  Long+repeat ch2, i_repeat_en[2]=1, hold 80 cycles -> o_long at press+31, o_repeat at +41,+51,+61.
//  Repeat disabled ch3 -> o_long only; release -> o_release[3] 10 cycles after edge, FSM K_IDLE.
//  Simultaneous press ch0..3 same cycle -> o_press=4'hF in one cycle; rst_n pulse mid-hold clears all.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-key debouncer.
//   key_state_e : per-channel press classifier state
//   cnt_width   : bit width of a counter that must be able to hold max_val
package key_pkg;

  typedef enum logic [1:0] {
    K_IDLE   = 2'd0,
    K_HELD   = 2'd1,
    K_REPEAT = 2'd2
  } key_state_e;

  // Width of a counter able to hold max_val without wrapping
  function automatic int cnt_width(input int unsigned max_val);
    return $clog2(64'(max_val) + 64'd1);
  endfunction

endpackage

// File: rtl/multi_key_debounce_if.sv
// Key front-end bundle between board pins / control logic and the debouncer.
//   i_key       : raw asynchronous key pins
//   i_repeat_en : per-channel auto-repeat enable
//   o_level     : debounced state, 1 = pressed
//   o_press     : 1-cycle pulse on accepted press
//   o_release   : 1-cycle pulse on accepted release
//   o_long      : 1-cycle pulse once per press after the long-hold time
//   o_repeat    : 1-cycle auto-repeat pulse after o_long
// master = the side driving the pins (board/bench), slave = the debouncer.
interface multi_key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] i_key;
  logic [N_KEYS-1:0] i_repeat_en;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_repeat;

  modport master (
    output i_key, i_repeat_en,
    input  o_level, o_press, o_release, o_long, o_repeat
  );

  modport slave (
    input  i_key, i_repeat_en,
    output o_level, o_press, o_release, o_long, o_repeat
  );
endinterface

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce counter and the
// press / long-press / auto-repeat classifier.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_key       : raw pin (polarity given by ACTIVE_LOW)
//   i_repeat_en : auto-repeat enable
//   o_level, o_press, o_release, o_long, o_repeat : registered outputs
module key_channel
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);

  localparam logic          REL_LVL   = ACTIVE_LOW;
  localparam logic [DW-1:0] DEB_TERM  = DW'(DEB_CYCLES - 1);
  // The long pulse fires on the edge where the hold counter steps onto
  // LONG_CYCLES-1, so it lands LONG_CYCLES-1 cycles after the press pulse.
  localparam logic [HW-1:0] HOLD_TERM = HW'(LONG_CYCLES - 2);
  // Repeat pulses fire after the counter has sat at REPEAT_CYCLES-1,
  // giving exactly REPEAT_CYCLES cycles between pulses.
  localparam logic [RW-1:0] RPT_TERM  = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          pressed_s;
  logic          flip_s;
  logic [DW-1:0] deb_cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic [RW-1:0] rpt_cnt_r;
  key_state_e    state_r;
  logic          level_r;
  logic          press_r;
  logic          release_r;
  logic          long_r;
  logic          repeat_r;

  // Two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {2{REL_LVL}};
    end else begin
      sync_r <= {sync_r[0], i_key};
    end
  end

  // Polarity normalisation and debounce acceptance
  always_comb begin
    pressed_s = ACTIVE_LOW ? ~sync_r[1] : sync_r[1];
    flip_s    = 1'b0;
    if ((pressed_s != level_r) && (deb_cnt_r == DEB_TERM)) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Debounce counter: counts consecutive cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r <= {DW{1'b0}};
    end else if ((pressed_s == level_r) || flip_s) begin
      deb_cnt_r <= {DW{1'b0}};
    end else begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end
  end

  // Classifier FSM with registered level and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= K_IDLE;
      level_r    <= 1'b0;
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      long_r     <= 1'b0;
      repeat_r   <= 1'b0;
      hold_cnt_r <= {HW{1'b0}};
      rpt_cnt_r  <= {RW{1'b0}};
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      if (flip_s) begin
        level_r <= pressed_s;
      end
      case (state_r)
        K_IDLE: begin
          hold_cnt_r <= {HW{1'b0}};
          rpt_cnt_r  <= {RW{1'b0}};
          if (flip_s && pressed_s) begin
            state_r <= K_HELD;
            press_r <= 1'b1;
          end
        end
        K_HELD: begin
          // Release is checked first so it wins over a coincident long count
          if (flip_s && !pressed_s) begin
            state_r    <= K_IDLE;
            release_r  <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
          end else if (hold_cnt_r == HOLD_TERM) begin
            state_r    <= K_REPEAT;
            long_r     <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
            rpt_cnt_r  <= {RW{1'b0}};
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        K_REPEAT: begin
          if (flip_s && !pressed_s) begin
            state_r   <= K_IDLE;
            release_r <= 1'b1;
            rpt_cnt_r <= {RW{1'b0}};
          end else if (i_repeat_en) begin
            if (rpt_cnt_r == RPT_TERM) begin
              repeat_r  <= 1'b1;
              rpt_cnt_r <= {RW{1'b0}};
            end else begin
              rpt_cnt_r <= rpt_cnt_r + RW'(1);
            end
          end else begin
            rpt_cnt_r <= rpt_cnt_r;
          end
        end
        default: begin
          state_r    <= K_IDLE;
          hold_cnt_r <= {HW{1'b0}};
          rpt_cnt_r  <= {RW{1'b0}};
        end
      endcase
    end
  end

  assign o_level   = level_r;
  assign o_press   = press_r;
  assign o_release = release_r;
  assign o_long    = long_r;
  assign o_repeat  = repeat_r;

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel push-button front end: synchronises, debounces and classifies
// raw keys into level, press, release, long-press and auto-repeat events.
//   clk   : system clock (CLOCK_50)
//   rst_n : asynchronous active-low reset
//   kif   : key bundle (slave side), see multi_key_debounce_if
module multi_key_debounce
  import key_pkg::*;
#(
  parameter int          N_KEYS        = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_key_debounce_if.slave   kif
);

  logic [N_KEYS-1:0] level_s;
  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] release_s;
  logic [N_KEYS-1:0] long_s;
  logic [N_KEYS-1:0] repeat_s;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_key       (kif.i_key[g]),
      .i_repeat_en (kif.i_repeat_en[g]),
      .o_level     (level_s[g]),
      .o_press     (press_s[g]),
      .o_release   (release_s[g]),
      .o_long      (long_s[g]),
      .o_repeat    (repeat_s[g])
    );
  end

  assign kif.o_level   = level_s;
  assign kif.o_press   = press_s;
  assign kif.o_release = release_s;
  assign kif.o_long    = long_s;
  assign kif.o_repeat  = repeat_s;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed self-checking bench for multi_key_debounce
// (N_KEYS=4, active-low keys, DEB=8, LONG=32, REPEAT=10).
module tb_multi_key_debounce;
  import key_pkg::*;

  localparam int NK = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cnt_press [NK] = '{default: 0};
  int   cnt_rel   [NK] = '{default: 0};
  int   cnt_long  [NK] = '{default: 0};
  int   cnt_rep   [NK] = '{default: 0};

  multi_key_debounce_if #(.N_KEYS(NK)) kif ();

  multi_key_debounce #(
    .N_KEYS        (NK),
    .ACTIVE_LOW    (1'b1),
    .DEB_CYCLES    (8),
    .LONG_CYCLES   (32),
    .REPEAT_CYCLES (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  always #5 clk = ~clk;

  // Event tally, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (kif.o_press[i])   cnt_press[i]++;
      if (kif.o_release[i]) cnt_rel[i]++;
      if (kif.o_long[i])    cnt_long[i]++;
      if (kif.o_repeat[i])  cnt_rep[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    kif.i_key       = 4'hF;
    kif.i_repeat_en = 4'b0100;
    #22;
    chk("rst_level",   32'(kif.o_level),   32'h0);
    chk("rst_press",   32'(kif.o_press),   32'h0);
    chk("rst_release", 32'(kif.o_release), 32'h0);
    chk("rst_long",    32'(kif.o_long),    32'h0);
    chk("rst_repeat",  32'(kif.o_repeat),  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(50);
    chk("idle_press_cnt", 32'(cnt_press[0] + cnt_press[1] + cnt_press[2] + cnt_press[3]), 32'd0);
    chk("idle_rel_cnt",   32'(cnt_rel[0] + cnt_rel[1] + cnt_rel[2] + cnt_rel[3]), 32'd0);
    chk("idle_level",     32'(kif.o_level), 32'h0);

    // Clean press and release on ch0
    kif.i_key[0] = 1'b0;
    tick(9);
    chk("ch0_level_early", 32'(kif.o_level), 32'h0);
    tick(1);
    chk("ch0_level",  32'(kif.o_level), 32'h1);
    chk("ch0_press",  32'(kif.o_press), 32'h1);
    tick(1);
    chk("ch0_press_1cyc", 32'(kif.o_press), 32'h0);
    kif.i_key[0] = 1'b1;
    tick(9);
    chk("ch0_rel_early", 32'(kif.o_release), 32'h0);
    tick(1);
    chk("ch0_release",   32'(kif.o_release), 32'h1);
    chk("ch0_level_off", 32'(kif.o_level),   32'h0);

    // Bounce on ch1: low 5, high 3, then steady low
    tick(2);
    kif.i_key[1] = 1'b0;
    tick(5);
    kif.i_key[1] = 1'b1;
    tick(3);
    kif.i_key[1] = 1'b0;
    tick(9);
    chk("ch1_press_early", 32'(kif.o_press), 32'h0);
    tick(1);
    chk("ch1_press", 32'(kif.o_press), 32'h2);
    tick(1);
    chk("ch1_press_cnt", 32'(cnt_press[1]), 32'd1);
    kif.i_key[1] = 1'b1;
    tick(12);

    // Long press plus auto-repeat on ch2; release coincides with a repeat slot
    kif.i_key[2] = 1'b0;
    tick(10);
    chk("ch2_press", 32'(kif.o_press), 32'h4);
    for (int t = 1; t <= 71; t++) begin
      tick(1);
      if (t == 30) chk("ch2_long_early", 32'(kif.o_long), 32'h0);
      if (t == 31) chk("ch2_long", 32'(kif.o_long), 32'h4);
      if (t == 40) chk("ch2_rep_early", 32'(kif.o_repeat), 32'h0);
      if (t == 41 || t == 51 || t == 61 || t == 71)
        chk($sformatf("ch2_repeat_%0d", t), 32'(kif.o_repeat), 32'h4);
    end
    kif.i_key[2] = 1'b1;
    tick(9);
    chk("ch2_rel_early", 32'(kif.o_release), 32'h0);
    tick(1);
    chk("ch2_release",     32'(kif.o_release), 32'h4);
    chk("ch2_rel_wins",    32'(kif.o_repeat),  32'h0);
    tick(2);
    chk("ch2_long_cnt", 32'(cnt_long[2]), 32'd1);
    chk("ch2_rep_cnt",  32'(cnt_rep[2]),  32'd4);

    // Long press on ch3 with repeat disabled
    kif.i_key[3] = 1'b0;
    tick(10);
    chk("ch3_press", 32'(kif.o_press), 32'h8);
    tick(31);
    chk("ch3_long", 32'(kif.o_long), 32'h8);
    tick(29);
    kif.i_key[3] = 1'b1;
    tick(9);
    chk("ch3_rel_early", 32'(kif.o_release), 32'h0);
    tick(1);
    chk("ch3_release", 32'(kif.o_release), 32'h8);
    chk("ch3_state",   32'(dut.g_ch[3].u_ch.state_r), 32'(K_IDLE));
    tick(2);
    chk("ch3_long_cnt", 32'(cnt_long[3]), 32'd1);
    chk("ch3_rep_cnt",  32'(cnt_rep[3]),  32'd0);

    // Simultaneous press on all channels, then reset mid-hold
    kif.i_key = 4'h0;
    tick(9);
    chk("all_press_early", 32'(kif.o_press), 32'h0);
    tick(1);
    chk("all_press", 32'(kif.o_press), 32'hF);
    chk("all_level", 32'(kif.o_level), 32'hF);
    tick(5);
    rst_n = 1'b0;
    #2;
    chk("midrst_level", 32'(kif.o_level), 32'h0);
    chk("midrst_long",  32'(kif.o_long),  32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    chk("repress_early", 32'(kif.o_press), 32'h0);
    tick(1);
    chk("repress", 32'(kif.o_press), 32'hF);
    kif.i_key = 4'hF;
    tick(12);
    chk("final_level", 32'(kif.o_level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
